// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU control codes and result-register state shared by alu_arbiter
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;
  localparam logic [3:0] ALU_NOR    = 4'b1100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational N-bit ALU; unsupported control codes yield zero
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctl,
  output logic [N-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_PASS_B: result = b;
      ALU_NOR:    result = ~(a | b);
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared ALU with a one-entry result register
// ALU_ARBITER_RR_EN selects round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [N-1:0] a_0,
  input  logic [N-1:0] b_0,
  input  logic [N-1:0] a_1,
  input  logic [N-1:0] b_1,
  input  logic [3:0]   ctl_0,
  input  logic [3:0]   ctl_1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_result,
  output logic         resp_zero
);

  state_t       state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         id_q, id_d;

  logic         drain, can_issue, accept;
  logic         gnt_any, gnt_id;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctl;
  logic         alu_zero;

  assign gnt_any = req_valid_0 | req_valid_1;

`ifdef ALU_ARBITER_RR_EN
  // prio_q names the requester that wins when both are valid
  logic prio_q, prio_d;

  always_comb begin
    gnt_id = req_valid_1;
    if (req_valid_0 && req_valid_1) gnt_id = prio_q;
  end

  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`else
  assign gnt_id = ~req_valid_0 & req_valid_1;
`endif

  assign drain     = (state_q == ST_FULL) && resp_ready;
  assign can_issue = !reset && ((state_q == ST_EMPTY) || drain);
  assign accept    = can_issue && gnt_any;

  assign req_ready_0 = accept && !gnt_id;
  assign req_ready_1 = accept &&  gnt_id;

  assign alu_a   = gnt_id ? a_1   : a_0;
  assign alu_b   = gnt_id ? b_1   : b_0;
  assign alu_ctl = gnt_id ? ctl_1 : ctl_0;

  alu #(.N(N)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctl    (alu_ctl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = ST_FULL;
      result_d = alu_result;
      zero_d   = alu_zero;
      id_d     = gnt_id;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      zero_q   <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
    end
  end

  assign resp_valid  = (state_q == ST_FULL);
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench: queue-based response model plus directed literal checks
module tb_alu_arbiter;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_0, req_valid_1;
  logic         req_ready_0, req_ready_1;
  logic [N-1:0] a_0, b_0, a_1, b_1;
  logic [3:0]   ctl_0, ctl_1;
  logic         resp_valid, resp_ready, resp_id, resp_zero;
  logic [N-1:0] resp_result;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
    .ctl_0(ctl_0), .ctl_1(ctl_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_zero(resp_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the opcode table
  function automatic logic [N-1:0] alu_ref(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // Model: a queue holding at most one outstanding response
  logic [N-1:0] q_res[$];
  bit           q_id[$];
  bit           m_prio  = 1'b0;
  bit           started = 1'b0;

  function automatic int model_grant();
    if (req_valid_0 && req_valid_1) begin
`ifdef ALU_ARBITER_RR_EN
      return m_prio ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req_valid_0) return 0;
    if (req_valid_1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit drn, can;
    started = 1'b1;
    if (reset) begin
      q_res.delete();
      q_id.delete();
      m_prio = 1'b0;
    end else begin
      g   = model_grant();
      drn = (q_res.size() != 0) && resp_ready;
      can = (q_res.size() == 0) || drn;
      if (drn) begin
        void'(q_res.pop_front());
        void'(q_id.pop_front());
      end
      if (can && g >= 0) begin
        q_res.push_back(g == 0 ? alu_ref(ctl_0, a_0, b_0) : alu_ref(ctl_1, a_1, b_1));
        q_id.push_back(g == 1);
        m_prio = (g == 0);
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    bit can;
    if (started) begin
      if (reset) begin
        chk("req_ready_0_in_reset", {63'd0, req_ready_0}, 64'd0);
        chk("req_ready_1_in_reset", {63'd0, req_ready_1}, 64'd0);
      end else begin
        g   = model_grant();
        can = (q_res.size() == 0) || resp_ready;
        chk("model_req_ready_0", {63'd0, req_ready_0}, {63'd0, can && g == 0});
        chk("model_req_ready_1", {63'd0, req_ready_1}, {63'd0, can && g == 1});
        chk("model_resp_valid", {63'd0, resp_valid}, {63'd0, q_res.size() != 0});
        if (q_res.size() != 0) begin
          chk("model_resp_id", {63'd0, resp_id}, {63'd0, q_id[0]});
          chk("model_resp_result", resp_result, q_res[0]);
          chk("model_resp_zero", {63'd0, resp_zero}, {63'd0, q_res[0] == '0});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  task automatic set0(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c);
    req_valid_0 = 1'b1; a_0 = a; b_0 = b; ctl_0 = c;
  endtask

  task automatic set1(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c);
    req_valid_1 = 1'b1; a_1 = a; b_1 = b; ctl_1 = c;
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b0;
    idle();
    a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0; ctl_0 = '0; ctl_1 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("reset_resp_result", resp_result, 64'd0);
    chk("reset_resp_id", {63'd0, resp_id}, 64'd0);
    chk("reset_resp_zero", {63'd0, resp_zero}, 64'd0);

    // Single request: 5 + 3
    resp_ready = 1'b1;
    set0(64'd5, 64'd3, 4'b0010);
    #1 chk("single_req_ready_0", {63'd0, req_ready_0}, 64'd1);
    tick(); idle(); #1;
    chk("single_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("single_resp_id", {63'd0, resp_id}, 64'd0);
    chk("single_resp_result", resp_result, 64'd8);
    chk("single_resp_zero", {63'd0, resp_zero}, 64'd0);

    // Zero flag via SUB on requester 1
    set1(64'd7, 64'd7, 4'b0110);
    tick(); idle(); #1;
    chk("sub_zero_result", resp_result, 64'd0);
    chk("sub_zero_flag", {63'd0, resp_zero}, 64'd1);
    chk("sub_zero_id", {63'd0, resp_id}, 64'd1);

    // Wrap-around
    set0({N{1'b1}}, 64'd1, 4'b0010);
    tick(); idle(); #1;
    chk("wrap_result", resp_result, 64'd0);
    chk("wrap_zero", {63'd0, resp_zero}, 64'd1);

    // Unsupported control code
    set1(64'd5, 64'd9, 4'b1111);
    #1 chk("unsup_req_ready_1", {63'd0, req_ready_1}, 64'd1);
    tick(); idle(); #1;
    chk("unsup_result", resp_result, 64'd0);
    chk("unsup_id", {63'd0, resp_id}, 64'd1);

    // Contention from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    set0(64'd10, 64'd1, 4'b0010);
    set1(64'd20, 64'd4, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef ALU_ARBITER_RR_EN
      chk("contend_id", {63'd0, resp_id}, (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("contend_result", resp_result, (i % 2 == 0) ? 64'd11 : 64'd16);
`else
      chk("contend_id", {63'd0, resp_id}, 64'd0);
      chk("contend_result", resp_result, 64'd11);
      chk("contend_req_ready_1", {63'd0, req_ready_1}, 64'd0);
`endif
    end
    idle(); tick();

    // Backpressure with a pending request on requester 1
    resp_ready = 1'b0;
    set0(64'hF0, 64'h0F, 4'b0001);
    tick();
    req_valid_0 = 1'b0;
    set1(64'd3, 64'd5, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_result", resp_result, 64'hFF);
      chk("bp_id", {63'd0, resp_id}, 64'd0);
      chk("bp_req_ready_0", {63'd0, req_ready_0}, 64'd0);
      chk("bp_req_ready_1", {63'd0, req_ready_1}, 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_req_ready_1", {63'd0, req_ready_1}, 64'd1);
    tick(); idle(); #1;
    chk("bp_b2b_valid", {63'd0, resp_valid}, 64'd1);
    chk("bp_b2b_id", {63'd0, resp_id}, 64'd1);
    chk("bp_b2b_result", resp_result, 64'd1);
    tick();

    // Reset while holding a result
    resp_ready = 1'b0;
    set0(64'd0, 64'd0, 4'b1100);
    tick(); idle(); #1;
    chk("pre_rst_result", resp_result, {N{1'b1}});
    reset = 1'b1;
    tick();
    set0(64'd1, 64'd1, 4'b0010);
    set1(64'd4, 64'd4, 4'b0010);
    #1;
    chk("midrst_valid", {63'd0, resp_valid}, 64'd0);
    chk("midrst_result", resp_result, 64'd0);
    chk("midrst_id", {63'd0, resp_id}, 64'd0);
    chk("midrst_zero", {63'd0, resp_zero}, 64'd0);
    chk("midrst_req_ready_0", {63'd0, req_ready_0}, 64'd0);
    reset = 1'b0; resp_ready = 1'b1;
    #1;
    chk("post_rst_req_ready_0", {63'd0, req_ready_0}, 64'd1);
    chk("post_rst_req_ready_1", {63'd0, req_ready_1}, 64'd0);
    tick(); idle(); #1;
    chk("post_rst_id", {63'd0, resp_id}, 64'd0);
    chk("post_rst_result", resp_result, 64'd2);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 64, operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have ports req_valid_0 / req_valid_1  input  1  requester 0/1 presents an operation.
REQ-005 The block SHALL have ports req_ready_0 / req_ready_1  output  1  requester 0/1 operation accepted this cycle.
REQ-006 The block SHALL have ports a_0, b_0, a_1, b_1  input  N  operands per requester.
REQ-007 The block SHALL have ports ctl_0 / ctl_1  input  4  ALUControl code per requester.
REQ-008 The block SHALL have port resp_valid  output  1  result register holds a valid result.
REQ-009 The block SHALL have port resp_ready  input  1  consumer accepts the result this cycle.
REQ-010 The block SHALL have ports resp_id  output  1, resp_result  output  N, resp_zero  output  1: originating requester, ALU result and zero flag.

Function
REQ-011 The block SHALL contain one shared ALU and a one-entry result register with states EMPTY and FULL.
REQ-012 The block SHALL treat a handshake as complete only on a cycle where valid and ready are both high.
REQ-013 The block SHALL set can_issue = (state == EMPTY) or (resp_valid and resp_ready).
REQ-014 The block SHALL raise at most one req_ready_x per cycle, only when can_issue and req_valid_x are high and x is granted.
REQ-015 The block SHALL compute the granted operation in the same cycle and register result, zero and id at the next edge: one-cycle latency from accept to resp_valid.
REQ-016 The block SHALL hold resp_result, resp_zero and resp_id stable while resp_valid is high and resp_ready is low.
REQ-017 Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on drain with no accept; FULL->FULL on simultaneous drain and accept (back-to-back, one result per cycle); otherwise hold.
REQ-018 The block SHALL NOT make req_ready_x combinationally depend on resp_ready except through can_issue.
REQ-019 The block SHALL pass ctl codes unchanged to the ALU; unsupported codes yield the ALU's default result without affecting handshakes.
REQ-020 The block SHALL produce N-bit results with carry-out discarded (wrap-around), and resp_zero = (result == 0).

Reset
REQ-021 While reset is high the block SHALL force state EMPTY, resp_valid 0, resp_id 0, resp_result 0, resp_zero 0, req_ready_0/1 0, and the round-robin pointer to requester 0.
REQ-022 Reset asserted mid-operation SHALL discard any held result; no response for it is ever issued.

Configuration
REQ-023 With macro ALU_ARBITER_RR_EN defined, the grant SHALL be round-robin: priority goes to the requester not granted last; the pointer updates only on an accept.
REQ-024 Without ALU_ARBITER_RR_EN, the grant SHALL be fixed priority, requester 0 over requester 1, and no pointer register is built.

Structure
REQ-025 A shared package SHALL hold the ALUControl code constants (AND 0000, OR 0001, ADD 0010, SUB 0110, PASS_B 0111, NOR 1100) and the EMPTY/FULL state enum.
REQ-026 The block SHALL instantiate the existing alu module as its single sub-module; the arbiter and register logic stay in alu_arbiter.

Verification
REQ-027 Reset then single request: req_valid_0=1, a_0=5, b_0=3, ctl_0=0010 -> req_ready_0=1 that cycle; next cycle resp_valid=1, resp_id=0, resp_result=8, resp_zero=0.
REQ-028 Zero and wrap-around: a_1=7, b_1=7, ctl_1=0110 -> resp_result=0, resp_zero=1, resp_id=1. ADD with a=2^64-1, b=1 -> resp_result=0, resp_zero=1.
REQ-029 Contention, both valid every cycle, resp_ready=1: with ALU_ARBITER_RR_EN, ids alternate 0,1,0,1 at one result per cycle; without it, ids are 0,0,0,0 and req_ready_1 stays 0.
REQ-030 Backpressure: hold resp_ready=0 for 3 cycles with FULL -> result and id unchanged and both req_ready low; raise resp_ready with a pending request -> drain and accept in the same cycle, state stays FULL.
REQ-031 Reset mid-operation: assert reset while FULL with resp_ready=0 -> next cycle resp_valid=0, all outputs 0, and the first grant after reset goes to requester 0.
